// File: rtl/jk_seq_pkg.sv
// Shared encodings for the JK counter sequencer: command opcodes and FSM states.
package jk_seq_pkg;

   localparam logic [1:0] OP_CLEAR = 2'b00;
   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_UP    = 2'b10;
   localparam logic [1:0] OP_DOWN  = 2'b11;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_APPLY = 2'd1;
   localparam logic [1:0] S_COUNT = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   // UP and DOWN share the high opcode bit; the low bit then selects direction.
   function automatic logic is_count_op(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop: 00 hold, 01 reset, 10 set, 11 toggle; async active-low reset to 0.
module jk_cell (
   input  logic clock,
   input  logic reset_n,
   input  logic j,
   input  logic k,
   output logic q
);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         q <= 1'b0;
      end else begin
         case ({j, k})
            2'b01:   q <= 1'b0;
            2'b10:   q <= 1'b1;
            2'b11:   q <= ~q;
            default: q <= q;
         endcase
      end
   end

endmodule

// File: rtl/jk_counter_sequencer.sv
// Command-driven counter built from a bank of JK flip-flops; the sequencer decides
// per-bit J/K every cycle and owns the bank.
//
// state   | meaning
// S_IDLE  | ready for a command, bank holds
// S_APPLY | one cycle of CLEAR/LOAD drive onto the bank
// S_COUNT | stepping up/down once per edge until steps run out or abort
// S_DONE  | one-cycle completion pulse, then back to idle
module jk_counter_sequencer
   import jk_seq_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int STEP_W = 8
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [WIDTH-1:0]  cmd_data,
   input  logic [STEP_W-1:0] cmd_steps,
   input  logic              abort,
   output logic [WIDTH-1:0]  q,
   output logic [WIDTH-1:0]  j_vec,
   output logic [WIDTH-1:0]  k_vec,
   output logic              busy,
   output logic              done,
   output logic              wrap
);

   logic [1:0]        state, state_next;
   logic [1:0]        op_r;
   logic [WIDTH-1:0]  data_r;
   logic [STEP_W-1:0] steps_left;
   logic [WIDTH-1:0]  tog;
   logic              run;
   logic              accept;
   logic              step_take;
   logic              wrap_hit;

   assign cmd_ready = (state == S_IDLE);
   assign accept    = cmd_valid && cmd_ready;
   assign step_take = (state == S_COUNT) && !abort;

   // A bit toggles when every lower bit is 1 (up) or 0 (down); bit 0 always toggles.
   always_comb begin
      tog = '0;
      run = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         tog[i] = run;
         run    = run & (op_r[0] ? ~q[i] : q[i]);
      end
   end

   // The step about to be taken wraps when q sits at the extreme for the direction.
   assign wrap_hit = step_take && (op_r[0] ? (q == '0) : (&q));

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (!is_count_op(cmd_op))   state_next = S_APPLY;
               else if (cmd_steps != '0)   state_next = S_COUNT;
               else                        state_next = S_DONE;
            end
         end
         S_APPLY: state_next = S_DONE;
         S_COUNT: begin
            if (abort || (steps_left == STEP_W'(1))) state_next = S_DONE;
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      j_vec = '0;
      k_vec = '0;
      case (state)
         S_APPLY: begin
            if (op_r == OP_CLEAR) begin
               k_vec = '1;
            end else begin
               j_vec = data_r;
               k_vec = ~data_r;
            end
         end
         S_COUNT: begin
            if (!abort) begin
               j_vec = tog;
               k_vec = tog;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         op_r       <= OP_CLEAR;
         data_r     <= '0;
         steps_left <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         wrap       <= 1'b0;
      end else begin
         state <= state_next;
         busy  <= (state_next != S_IDLE);
         done  <= (state_next == S_DONE);
         wrap  <= wrap_hit;
         if (accept) begin
            op_r       <= cmd_op;
            data_r     <= cmd_data;
            steps_left <= is_count_op(cmd_op) ? cmd_steps : '0;
         end else if (step_take) begin
            steps_left <= steps_left - STEP_W'(1);
         end else if (state == S_COUNT) begin
            steps_left <= '0;
         end
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bank
      jk_cell u_cell (
         .clock   (clock),
         .reset_n (reset_n),
         .j       (j_vec[i]),
         .k       (k_vec[i]),
         .q       (q[i])
      );
   end

endmodule

// File: tb/tb_jk_counter_sequencer.sv
// Directed bench for jk_counter_sequencer; expected per-cycle outputs go through a scoreboard queue.
module tb_jk_counter_sequencer;
   import jk_seq_pkg::*;

   logic       clock;
   logic       reset_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [3:0] cmd_data;
   logic [7:0] cmd_steps;
   logic       abort;
   logic [3:0] q;
   logic [3:0] j_vec;
   logic [3:0] k_vec;
   logic       busy;
   logic       done;
   logic       wrap;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [3:0] q;
      logic [3:0] j;
      logic [3:0] k;
      logic       done;
      logic       wrap;
      logic       busy;
      logic       ready;
   } exp_t;

   exp_t  sb[$];
   string tags[$];

   jk_counter_sequencer #(.WIDTH(4), .STEP_W(8)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .cmd_steps (cmd_steps),
      .abort     (abort),
      .q         (q),
      .j_vec     (j_vec),
      .k_vec     (k_vec),
      .busy      (busy),
      .done      (done),
      .wrap      (wrap)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic cmp(input string tag, input string fld, input logic [3:0] got, input logic [3:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s.%s observed %h expected %h", tag, fld, got, want);
      end
   endtask

   task automatic push(input string tag, input logic [3:0] eq, input logic [3:0] ej, input logic [3:0] ek,
                       input logic ed, input logic ew, input logic eb, input logic er);
      exp_t e;
      e.q = eq; e.j = ej; e.k = ek; e.done = ed; e.wrap = ew; e.busy = eb; e.ready = er;
      sb.push_back(e);
      tags.push_back(tag);
   endtask

   task automatic check();
      exp_t  e;
      string t;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_empty observed 0 entries expected 1");
      end else begin
         e = sb.pop_front();
         t = tags.pop_front();
         cmp(t, "q",     q,     e.q);
         cmp(t, "j_vec", j_vec, e.j);
         cmp(t, "k_vec", k_vec, e.k);
         cmp(t, "done",  {3'b0, done},      {3'b0, e.done});
         cmp(t, "wrap",  {3'b0, wrap},      {3'b0, e.wrap});
         cmp(t, "busy",  {3'b0, busy},      {3'b0, e.busy});
         cmp(t, "ready", {3'b0, cmd_ready}, {3'b0, e.ready});
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic step(input string tag, input logic [3:0] eq, input logic [3:0] ej, input logic [3:0] ek,
                       input logic ed, input logic ew, input logic eb, input logic er);
      push(tag, eq, ej, ek, ed, ew, eb, er);
      tick();
      check();
   endtask

   task automatic issue(input logic [1:0] op, input logic [3:0] data, input logic [7:0] steps);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      cmd_steps = steps;
   endtask

   initial begin
      reset_n   = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = OP_CLEAR;
      cmd_data  = 4'h0;
      cmd_steps = 8'd0;
      abort     = 1'b0;
      repeat (2) @(posedge clock);
      #3 reset_n = 1'b1;
      push("reset", 4'h0, 4'h0, 4'h0, 0, 0, 0, 1);
      check();

      // LOAD A
      issue(OP_LOAD, 4'hA, 8'd0);
      step("ld_a_e0", 4'h0, 4'hA, 4'h5, 0, 0, 1, 0);
      cmd_valid = 1'b0;
      step("ld_a_e1", 4'hA, 4'h0, 4'h0, 1, 0, 1, 0);
      step("ld_a_e2", 4'hA, 4'h0, 4'h0, 0, 0, 0, 1);

      // LOAD E then UP 3: F, 0 (wrap), 1
      issue(OP_LOAD, 4'hE, 8'd0);
      step("ld_e_e0", 4'hA, 4'hE, 4'h1, 0, 0, 1, 0);
      cmd_valid = 1'b0;
      step("ld_e_e1", 4'hE, 4'h0, 4'h0, 1, 0, 1, 0);
      step("ld_e_e2", 4'hE, 4'h0, 4'h0, 0, 0, 0, 1);
      issue(OP_UP, 4'h0, 8'd3);
      step("up3_e0", 4'hE, 4'h1, 4'h1, 0, 0, 1, 0);
      cmd_valid = 1'b0;
      step("up3_e1", 4'hF, 4'hF, 4'hF, 0, 0, 1, 0);
      step("up3_e2", 4'h0, 4'h1, 4'h1, 0, 1, 1, 0);
      step("up3_e3", 4'h1, 4'h0, 4'h0, 1, 0, 1, 0);
      step("up3_e4", 4'h1, 4'h0, 4'h0, 0, 0, 0, 1);

      // LOAD 5, CLEAR (no wrap), DOWN 2: F (wrap), E
      issue(OP_LOAD, 4'h5, 8'd0);
      step("ld_5_e0", 4'h1, 4'h5, 4'hA, 0, 0, 1, 0);
      cmd_valid = 1'b0;
      step("ld_5_e1", 4'h5, 4'h0, 4'h0, 1, 0, 1, 0);
      step("ld_5_e2", 4'h5, 4'h0, 4'h0, 0, 0, 0, 1);
      issue(OP_CLEAR, 4'h7, 8'd9);
      step("clr_e0", 4'h5, 4'h0, 4'hF, 0, 0, 1, 0);
      cmd_valid = 1'b0;
      step("clr_e1", 4'h0, 4'h0, 4'h0, 1, 0, 1, 0);
      step("clr_e2", 4'h0, 4'h0, 4'h0, 0, 0, 0, 1);
      issue(OP_DOWN, 4'h0, 8'd2);
      step("dn2_e0", 4'h0, 4'hF, 4'hF, 0, 0, 1, 0);
      cmd_valid = 1'b0;
      step("dn2_e1", 4'hF, 4'h1, 4'h1, 0, 1, 1, 0);
      step("dn2_e2", 4'hE, 4'h0, 4'h0, 1, 0, 1, 0);
      step("dn2_e3", 4'hE, 4'h0, 4'h0, 0, 0, 0, 1);

      // LOAD F must not pulse wrap
      issue(OP_LOAD, 4'hF, 8'd0);
      step("ld_f_e0", 4'hE, 4'hF, 4'h0, 0, 0, 1, 0);
      cmd_valid = 1'b0;
      step("ld_f_e1", 4'hF, 4'h0, 4'h0, 1, 0, 1, 0);
      step("ld_f_e2", 4'hF, 4'h0, 4'h0, 0, 0, 0, 1);

      // CLEAR, then UP 200 aborted in the 5th COUNT cycle
      issue(OP_CLEAR, 4'h0, 8'd0);
      step("clr2_e0", 4'hF, 4'h0, 4'hF, 0, 0, 1, 0);
      cmd_valid = 1'b0;
      step("clr2_e1", 4'h0, 4'h0, 4'h0, 1, 0, 1, 0);
      step("clr2_e2", 4'h0, 4'h0, 4'h0, 0, 0, 0, 1);
      issue(OP_UP, 4'h0, 8'd200);
      step("ab_e0", 4'h0, 4'h1, 4'h1, 0, 0, 1, 0);
      cmd_valid = 1'b0;
      step("ab_e1", 4'h1, 4'h3, 4'h3, 0, 0, 1, 0);
      step("ab_e2", 4'h2, 4'h1, 4'h1, 0, 0, 1, 0);
      step("ab_e3", 4'h3, 4'h7, 4'h7, 0, 0, 1, 0);
      step("ab_e4", 4'h4, 4'h1, 4'h1, 0, 0, 1, 0);
      abort = 1'b1;
      #1;
      push("ab_drive", 4'h4, 4'h0, 4'h0, 0, 0, 1, 0);
      check();
      step("ab_e5", 4'h4, 4'h0, 4'h0, 1, 0, 1, 0);
      abort = 1'b0;
      step("ab_e6", 4'h4, 4'h0, 4'h0, 0, 0, 0, 1);

      // UP 2 with a LOAD 9 held on the port throughout
      issue(OP_UP, 4'h0, 8'd2);
      step("hold_e0", 4'h4, 4'h1, 4'h1, 0, 0, 1, 0);
      issue(OP_LOAD, 4'h9, 8'd0);
      step("hold_e1", 4'h5, 4'h3, 4'h3, 0, 0, 1, 0);
      step("hold_e2", 4'h6, 4'h0, 4'h0, 1, 0, 1, 0);
      step("hold_e3", 4'h6, 4'h0, 4'h0, 0, 0, 0, 1);
      step("hold_e4", 4'h6, 4'h9, 4'h6, 0, 0, 1, 0);
      cmd_valid = 1'b0;
      step("hold_e5", 4'h9, 4'h0, 4'h0, 1, 0, 1, 0);
      step("hold_e6", 4'h9, 4'h0, 4'h0, 0, 0, 0, 1);
      step("hold_e7", 4'h9, 4'h0, 4'h0, 0, 0, 0, 1);

      // UP with zero steps
      issue(OP_UP, 4'h0, 8'd0);
      step("up0_e0", 4'h9, 4'h0, 4'h0, 1, 0, 1, 0);
      cmd_valid = 1'b0;
      step("up0_e1", 4'h9, 4'h0, 4'h0, 0, 0, 0, 1);

      // Async reset between edges of a COUNT run
      issue(OP_UP, 4'h0, 8'd10);
      step("rst_e0", 4'h9, 4'h3, 4'h3, 0, 0, 1, 0);
      cmd_valid = 1'b0;
      step("rst_e1", 4'hA, 4'h1, 4'h1, 0, 0, 1, 0);
      #3 reset_n = 1'b0;
      #1;
      push("rst_mid", 4'h0, 4'h0, 4'h0, 0, 0, 0, 1);
      check();
      #2 reset_n = 1'b1;
      issue(OP_LOAD, 4'h3, 8'd0);
      step("ld_3_e0", 4'h0, 4'h3, 4'hC, 0, 0, 1, 0);
      cmd_valid = 1'b0;
      step("ld_3_e1", 4'h3, 4'h0, 4'h0, 1, 0, 1, 0);
      step("ld_3_e2", 4'h3, 4'h0, 4'h0, 0, 0, 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
